// File: rtl/pid_pkg.sv
// ============================================================================
// Module : pid_pkg
// Brief  : Shared types, constants and helpers for the PID soft-start path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pid_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } ss_state_t;

  localparam logic [7:0] SS_FULL = 8'hFF;

  // Clip a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] val,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pid_slew_lim.sv
// ============================================================================
// Module : pid_slew_lim
// Brief  : Output register with per-update slew limit and immediate clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pid_slew_lim
  import pid_pkg::*;
#(
  parameter int OUT_W    = 12,
  parameter int SLEW_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OUT_W-1:0] target_i,
  input  logic             upd_i,
  input  logic             force_zero_i,
  output logic [OUT_W-1:0] ctrl_out_o,
  output logic             out_vld_o
);

  localparam logic signed [OUT_W:0]   STEP_W = (OUT_W + 1)'(SLEW_MAX);
  localparam logic signed [OUT_W-1:0] STEP_O = OUT_W'(SLEW_MAX);

  logic signed [OUT_W-1:0] ctrl_q;
  logic signed [OUT_W-1:0] ctrl_d;
  logic                    out_vld_q;
  logic signed [OUT_W:0]   w_delta;

  // One extra bit so the difference of two full-range values cannot wrap.
  assign w_delta = (OUT_W + 1)'($signed(target_i)) - (OUT_W + 1)'(ctrl_q);

  always_comb begin
    ctrl_d = ctrl_q;
    if (force_zero_i) begin
      ctrl_d = '0;
    end else if (upd_i) begin
      if (w_delta > STEP_W) begin
        ctrl_d = ctrl_q + STEP_O;
      end else if (w_delta < -STEP_W) begin
        ctrl_d = ctrl_q - STEP_O;
      end else begin
        ctrl_d = $signed(target_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q    <= '0;
      out_vld_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      out_vld_q <= upd_i & ~force_zero_i;
    end
  end

  assign ctrl_out_o = ctrl_q;
  assign out_vld_o  = out_vld_q;

endmodule

`default_nettype wire

// File: rtl/pid_ss_slew_ctrl.sv
// ============================================================================
// Module : pid_ss_slew_ctrl
// Brief  : 3-stage PID balance controller with soft-start ramp, anti-windup
//          integrator and slew-limited output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pid_ss_slew_ctrl
  import pid_pkg::*;
#(
  parameter int ERR_W    = 10,
  parameter int OUT_W    = 12,
  parameter int INT_W    = 18,
  parameter int I_SHIFT  = 6,
  parameter int D_SHIFT  = 6,
  parameter int TMR_W    = 27,
  parameter int SS_INC   = 1,
  parameter int SLEW_MAX = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld,
  input  logic [15:0]      ptch,
  input  logic [15:0]      ptch_rt,
  input  logic [4:0]       p_gain,
  input  logic             pwr_up,
  input  logic             rider_off,
  output logic [OUT_W-1:0] ctrl_out,
  output logic             out_vld,
  output logic [7:0]       ss_tmr,
  output logic             sat
);

  localparam int D_W   = 17;
  localparam int P_W   = ERR_W + 6;
  localparam int SUM_W = max_int(max_int(OUT_W + 6, P_W), max_int(INT_W, D_W)) + 2;

  // Soft-start state machine and timer
  ss_state_t        state_q;
  ss_state_t        state_d;
  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_d;
  logic [TMR_W:0]   w_tmr_sum;

  assign ss_tmr    = timer_q[TMR_W-1 -: 8];
  assign w_tmr_sum = {1'b0, timer_q} + (TMR_W + 1)'(SS_INC);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      OFF: begin
        timer_d = '0;
        if (pwr_up) state_d = RAMP;
      end
      RAMP: begin
        if (ss_tmr == SS_FULL) begin
          state_d = RUN;
        end else begin
          timer_d = w_tmr_sum[TMR_W] ? '1 : w_tmr_sum[TMR_W-1:0];
        end
      end
      RUN:     state_d = RUN;
      default: state_d = OFF;
    endcase
    if (!pwr_up) begin
      state_d = OFF;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OFF;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Stage 1: saturate error, form D term, capture gain
  logic                    s1_vld_q;
  logic                    s1_rider_q;
  logic signed [ERR_W-1:0] err_sat_q;
  logic signed [D_W-1:0]   d_q;
  logic [4:0]              p_gain_q;
  logic                    w_s1_go;
  logic signed [ERR_W-1:0] w_err_sat;
  logic signed [D_W-1:0]   w_rt_ext;
  logic signed [D_W-1:0]   w_d;

  assign w_s1_go   = vld & pwr_up;
  assign w_err_sat = ERR_W'(sat_signed(64'($signed(ptch)), ERR_W));
  assign w_rt_ext  = {ptch_rt[15], ptch_rt};
  assign w_d       = -(w_rt_ext >>> D_SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_rider_q <= 1'b0;
      err_sat_q  <= '0;
      d_q        <= '0;
      p_gain_q   <= '0;
    end else begin
      s1_vld_q <= w_s1_go;
      if (w_s1_go) begin
        s1_rider_q <= rider_off;
        err_sat_q  <= w_err_sat;
        d_q        <= w_d;
        p_gain_q   <= p_gain;
      end
    end
  end

  // Stage 2: integrator update and saturated PID sum
  logic                    s2_vld_q;
  logic signed [INT_W-1:0] integ_q;
  logic signed [INT_W-1:0] integ_d;
  logic signed [OUT_W-1:0] pid_raw_q;
  logic                    sat_q;
  logic                    w_s2_go;
  logic signed [INT_W:0]   w_int_sum;
  logic                    w_int_ovf;
  logic                    w_windup;
  logic signed [5:0]       w_pg;
  logic signed [P_W-1:0]   w_p;
  logic signed [INT_W-1:0] w_i;
  logic signed [SUM_W-1:0] w_sum;
  logic signed [OUT_W-1:0] w_raw;
  logic                    w_clip;

  assign w_s2_go   = s1_vld_q & pwr_up;
  assign w_int_sum = (INT_W + 1)'(integ_q) + (INT_W + 1)'(err_sat_q);
  assign w_int_ovf = w_int_sum[INT_W] != w_int_sum[INT_W-1];
  // Hold the integrator while the last sum was clipped in the same direction.
  assign w_windup  = sat_q & (err_sat_q[ERR_W-1] == pid_raw_q[OUT_W-1]);

  always_comb begin
    integ_d = integ_q;
    if (rider_off || (w_s2_go && s1_rider_q)) begin
      integ_d = '0;
    end else if (w_s2_go && !w_int_ovf && !w_windup) begin
      integ_d = w_int_sum[INT_W-1:0];
    end
  end

  assign w_pg   = {1'b0, p_gain_q};
  assign w_p    = w_pg * err_sat_q;
  assign w_i    = integ_d >>> I_SHIFT;
  assign w_sum  = SUM_W'(w_p) + SUM_W'(w_i) + SUM_W'(d_q);
  assign w_raw  = OUT_W'(sat_signed(64'(w_sum), OUT_W));
  assign w_clip = SUM_W'(w_raw) != w_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      integ_q   <= '0;
      pid_raw_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      s2_vld_q <= w_s2_go;
      integ_q  <= integ_d;
      if (w_s2_go) begin
        pid_raw_q <= w_raw;
        sat_q     <= w_clip;
      end
    end
  end

  assign sat = sat_q;

  // Stage 3: soft-start scaling, then slew limiting
  logic                    w_s3_go;
  logic signed [OUT_W+8:0] w_prod;
  logic [OUT_W-1:0]        w_target;

  assign w_s3_go  = s2_vld_q & pwr_up;
  assign w_prod   = $signed({1'b0, ss_tmr}) * pid_raw_q;
  assign w_target = OUT_W'(w_prod >>> 8);

  pid_slew_lim #(
    .OUT_W    (OUT_W),
    .SLEW_MAX (SLEW_MAX)
  ) u_slew (
    .clk          (clk),
    .rst_n        (rst_n),
    .target_i     (w_target),
    .upd_i        (w_s3_go),
    .force_zero_i (~pwr_up),
    .ctrl_out_o   (ctrl_out),
    .out_vld_o    (out_vld)
  );

endmodule

`default_nettype wire

// File: tb/tb_pid_ss_slew_ctrl.sv
// ============================================================================
// Module : tb_pid_ss_slew_ctrl
// Brief  : Scoreboard bench for pid_ss_slew_ctrl (fast soft-start timer).
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pid_ss_slew_ctrl;

  localparam int OUT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             vld;
  logic [15:0]      ptch;
  logic [15:0]      ptch_rt;
  logic [4:0]       p_gain;
  logic             pwr_up;
  logic             rider_off;
  logic [OUT_W-1:0] ctrl_out;
  logic             out_vld;
  logic [7:0]       ss_tmr;
  logic             sat;

  always #5 clk = ~clk;

  pid_ss_slew_ctrl #(
    .ERR_W(10), .OUT_W(OUT_W), .INT_W(18), .I_SHIFT(6), .D_SHIFT(6),
    .TMR_W(27), .SS_INC(65536), .SLEW_MAX(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld       (vld),
    .ptch      (ptch),
    .ptch_rt   (ptch_rt),
    .p_gain    (p_gain),
    .pwr_up    (pwr_up),
    .rider_off (rider_off),
    .ctrl_out  (ctrl_out),
    .out_vld   (out_vld),
    .ss_tmr    (ss_tmr),
    .sat       (sat)
  );

  typedef struct {
    int ctrl;
    bit sat;
    bit chk_sat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  // Reference model state (valid while ss_tmr is full scale)
  int m_integ    = 0;
  int m_ctrl     = 0;
  int m_prev_raw = 0;
  bit m_prev_sat = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (out_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_vld actual=1 expected=0 ctrl_out=%0d", $signed(ctrl_out));
      end else begin
        mon_e = sb_q.pop_front();
        check("ctrl_out", $signed(ctrl_out), mon_e.ctrl);
        if (mon_e.chk_sat) check("sat", 32'(sat), 32'(mon_e.sat));
      end
    end
  end

  task automatic issue(input int pg, input int pt, input int rt, input bit rider,
                       input bit spaced);
    int err, d, n, i, sum, raw, tgt, dl;
    bit clip;
    @(negedge clk);
    p_gain    = pg[4:0];
    ptch      = pt[15:0];
    ptch_rt   = rt[15:0];
    rider_off = rider;
    vld       = 1'b1;
    err = (pt > 511) ? 511 : ((pt < -512) ? -512 : pt);
    d   = -(rt >>> 6);
    if (rider) begin
      m_integ = 0;
    end else begin
      n = m_integ + err;
      if (n <= 131071 && n >= -131072 &&
          !(m_prev_sat && ((err < 0) == (m_prev_raw < 0))))
        m_integ = n;
    end
    i    = m_integ >>> 6;
    sum  = pg * err + i + d;
    raw  = (sum > 2047) ? 2047 : ((sum < -2048) ? -2048 : sum);
    clip = (raw != sum);
    tgt  = (255 * raw) >>> 8;
    dl   = tgt - m_ctrl;
    if (dl > 64)       m_ctrl = m_ctrl + 64;
    else if (dl < -64) m_ctrl = m_ctrl - 64;
    else               m_ctrl = tgt;
    m_prev_sat = clip;
    m_prev_raw = raw;
    sb_q.push_back('{m_ctrl, clip, spaced});
    if (spaced) begin
      @(negedge clk);
      vld       = 1'b0;
      rider_off = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic end_burst();
    @(negedge clk);
    vld       = 1'b0;
    rider_off = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl_out"}, $signed(ctrl_out), 0);
    check({tag, "_out_vld"},  32'(out_vld), 0);
    check({tag, "_ss_tmr"},   32'(ss_tmr), 0);
    check({tag, "_sat"},      32'(sat), 0);
  endtask

  initial begin
    rst_n = 1'b0; vld = 1'b0; ptch = '0; ptch_rt = '0; p_gain = '0;
    pwr_up = 1'b0; rider_off = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) rst_n = 1'b1;

    // Soft start ramp to full scale, then hold
    @(negedge clk) pwr_up = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (ss_tmr == 8'hFF) break;
    end
    check("ramp_full", 32'(ss_tmr), 255);
    repeat (5) @(posedge clk);
    #1 check("ramp_hold", 32'(ss_tmr), 255);

    // P dominant, slewing up toward ~897
    for (int k = 0; k < 6; k++) issue(9, 100, 0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) issue(9, 100, 0, 1'b0, 1'b0);
    end_burst();
    wait_drain();

    // rider_off clears integrator; then pure D term (+100)
    issue(9, 100, 0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) issue(9, 0, -6400, 1'b0, 1'b1);

    // Saturation and anti-windup, both polarities
    for (int k = 0; k < 4; k++) issue(9, 28672, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) issue(31, -30000, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) issue(2, -50, 640, 1'b0, 1'b0);
    end_burst();
    wait_drain();

    // Power down with two samples in flight
    @(negedge clk);
    p_gain = 5'd9; ptch = 16'h7000; ptch_rt = '0; vld = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vld = 1'b0; pwr_up = 1'b0;
    @(posedge clk);
    #1;
    check("pwrdn_ctrl_out", $signed(ctrl_out), 0);
    check("pwrdn_ss_tmr", 32'(ss_tmr), 0);
    check("pwrdn_out_vld", 32'(out_vld), 0);
    @(posedge clk);
    #1 check("pwrdn_out_vld_late", 32'(out_vld), 0);

    // Reset mid-stream with samples in flight
    @(negedge clk) pwr_up = 1'b1;
    repeat (2) @(negedge clk);
    p_gain = 5'd9; ptch = 16'h7000; vld = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk) begin rst_n = 1'b1; vld = 1'b0; end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 check_idle("post_reset");
    end

    repeat (4) @(posedge clk);
    #2 check("final_queue", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
